// File: rtl/tl_ul_master_port.sv
// tl_ul_master_port
//   Single-beat TileLink-UL initiator. A simple cmd/rsp access port is turned
//   into A-channel Get/PutFullData requests, and D-channel acks are consumed.
//   Up to NSLOT = 2^SOURCE_BITS accesses may be outstanding. D beats may come
//   back in any source order; responses are returned on rsp in command order.
//
// Ports
//   clock, reset_n            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       access request handshake
//   cmd_write/addr/size/wdata request attributes (wdata right-justified)
//   rsp_valid/rsp_ready       response handshake (held until rsp_ready)
//   rsp_rdata/rsp_error       right-justified read data, error flag
//   a_*                       TL-UL A channel (registered)
//   d_*                       TL-UL D channel
//   proto_err                 sticky flag: an illegal D beat was observed
module tl_ul_master_port #(
    parameter int SOURCE_BITS = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [1:0]             cmd_size,
    input  logic [31:0]            cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_error,
    output logic                   a_valid,
    input  logic                   a_ready,
    output logic [2:0]             a_opcode,
    output logic [2:0]             a_param,
    output logic [1:0]             a_size,
    output logic [SOURCE_BITS-1:0] a_source,
    output logic [ADDR_W-1:0]      a_address,
    output logic [3:0]             a_mask,
    output logic [31:0]            a_data,
    input  logic                   d_valid,
    output logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SOURCE_BITS-1:0] d_source,
    input  logic                   d_denied,
    input  logic                   d_corrupt,
    input  logic [31:0]            d_data,
    output logic                   proto_err
);
    localparam int NSLOT = 1 << SOURCE_BITS;

    logic [NSLOT-1:0]       busy_q, busy_d, done_q, done_d, write_q, write_d, err_q, err_d;
    logic [1:0]             addr_q [NSLOT];
    logic [1:0]             addr_d [NSLOT];
    logic [1:0]             size_q [NSLOT];
    logic [1:0]             size_d [NSLOT];
    logic [31:0]            data_q [NSLOT];
    logic [31:0]            data_d [NSLOT];
    logic [SOURCE_BITS-1:0] alloc_ptr_q, alloc_ptr_d, ret_ptr_q, ret_ptr_d;
    logic                   a_valid_q, a_valid_d, a_write_q, a_write_d;
    logic [1:0]             a_size_q, a_size_d;
    logic [SOURCE_BITS-1:0] a_source_q, a_source_d;
    logic [ADDR_W-1:0]      a_address_q, a_address_d;
    logic [3:0]             a_mask_q, a_mask_d;
    logic [31:0]            a_data_q, a_data_d;
    logic                   proto_err_q, proto_err_d;

    logic        accept, retire, misalign, d_legal;
    logic [3:0]  cmd_mask;
    logic [31:0] rd_shift, rd_data;

    // A full table cannot accept; a stalled A beat also blocks new commands
    // because the A register has nowhere to put the next request.
    assign cmd_ready = reset_n & ~(&busy_q) & ~(a_valid_q & ~a_ready);
    assign accept    = cmd_valid & cmd_ready;
    assign rsp_valid = busy_q[ret_ptr_q] & done_q[ret_ptr_q];
    assign retire    = rsp_valid & rsp_ready;
    assign rsp_rdata = data_q[ret_ptr_q];
    assign rsp_error = err_q[ret_ptr_q];
    assign d_ready   = reset_n;

    assign a_valid   = a_valid_q;
    assign a_opcode  = a_write_q ? 3'd0 : 3'd4;
    assign a_param   = 3'd0;
    assign a_size    = a_size_q;
    assign a_source  = a_source_q;
    assign a_address = a_address_q;
    assign a_mask    = a_mask_q;
    assign a_data    = a_data_q;
    assign proto_err = proto_err_q;

    always_comb begin
        misalign = (cmd_size == 2'd3) | ((cmd_size == 2'd1) & cmd_addr[0]) |
                   ((cmd_size == 2'd2) & (|cmd_addr[1:0]));
        case (cmd_size)
            2'd0:    cmd_mask = 4'b0001 << cmd_addr[1:0];
            2'd1:    cmd_mask = cmd_addr[1] ? 4'b1100 : 4'b0011;
            default: cmd_mask = 4'b1111;
        endcase

        d_legal  = busy_q[d_source] & ~done_q[d_source] &
                   (d_opcode == (write_q[d_source] ? 3'd0 : 3'd1));
        rd_shift = d_data >> {addr_q[d_source], 3'b000};
        case (size_q[d_source])
            2'd0:    rd_data = {24'd0, rd_shift[7:0]};
            2'd1:    rd_data = {16'd0, rd_shift[15:0]};
            default: rd_data = rd_shift;
        endcase
    end

    always_comb begin
        busy_d      = busy_q;
        done_d      = done_q;
        write_d     = write_q;
        err_d       = err_q;
        addr_d      = addr_q;
        size_d      = size_q;
        data_d      = data_q;
        alloc_ptr_d = alloc_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        a_valid_d   = a_valid_q;
        a_write_d   = a_write_q;
        a_size_d    = a_size_q;
        a_source_d  = a_source_q;
        a_address_d = a_address_q;
        a_mask_d    = a_mask_q;
        a_data_d    = a_data_q;
        proto_err_d = proto_err_q;

        if (a_valid_q && a_ready) a_valid_d = 1'b0;

        if (retire) begin
            busy_d[ret_ptr_q] = 1'b0;
            done_d[ret_ptr_q] = 1'b0;
            ret_ptr_d         = ret_ptr_q + SOURCE_BITS'(1);
        end

        // The allocated slot is always free, so it never collides with the
        // retiring slot or with a legal D beat (which needs busy_q set).
        if (accept) begin
            busy_d[alloc_ptr_q]  = 1'b1;
            done_d[alloc_ptr_q]  = misalign;
            err_d[alloc_ptr_q]   = misalign;
            write_d[alloc_ptr_q] = cmd_write;
            addr_d[alloc_ptr_q]  = cmd_addr[1:0];
            size_d[alloc_ptr_q]  = cmd_size;
            data_d[alloc_ptr_q]  = 32'd0;
            alloc_ptr_d          = alloc_ptr_q + SOURCE_BITS'(1);
            if (!misalign) begin
                a_valid_d   = 1'b1;
                a_write_d   = cmd_write;
                a_size_d    = cmd_size;
                a_source_d  = alloc_ptr_q;
                a_address_d = cmd_addr;
                a_mask_d    = cmd_mask;
                a_data_d    = cmd_write ? (cmd_wdata << {cmd_addr[1:0], 3'b000}) : 32'd0;
            end
        end

        if (d_valid) begin
            if (d_legal) begin
                done_d[d_source] = 1'b1;
                err_d[d_source]  = d_denied | (~write_q[d_source] & d_corrupt);
                data_d[d_source] = write_q[d_source] ? 32'd0 : rd_data;
            end else begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= '0;
            done_q      <= '0;
            write_q     <= '0;
            err_q       <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                addr_q[i] <= '0;
                size_q[i] <= '0;
                data_q[i] <= '0;
            end
            alloc_ptr_q <= '0;
            ret_ptr_q   <= '0;
            a_valid_q   <= 1'b0;
            a_write_q   <= 1'b0;
            a_size_q    <= '0;
            a_source_q  <= '0;
            a_address_q <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            write_q     <= write_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            data_q      <= data_d;
            alloc_ptr_q <= alloc_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            a_valid_q   <= a_valid_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_source_q  <= a_source_d;
            a_address_q <= a_address_d;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_tl_ul_master_port.sv
module tb_tl_ul_master_port;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [1:0]  cmd_size = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_error;
    logic [31:0] rsp_rdata;
    logic        a_valid, a_ready = 1'b0;
    logic [2:0]  a_opcode, a_param;
    logic [1:0]  a_size, a_source;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    logic        d_valid = 1'b0, d_ready, d_denied = 1'b0, d_corrupt = 1'b0;
    logic [2:0]  d_opcode = '0;
    logic [1:0]  d_source = '0;
    logic [31:0] d_data = '0;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    tl_ul_master_port #(.SOURCE_BITS(2), .ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
        .d_denied(d_denied), .d_corrupt(d_corrupt), .d_data(d_data),
        .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        a_ready   = 1'b0;
        d_valid   = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Presents a command and holds it until it is accepted (bounded wait).
    task automatic issue_cmd(input logic w, input logic [31:0] addr, input logic [1:0] sz,
                             input logic [31:0] wd);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = addr;
        cmd_size  = sz;
        cmd_wdata = wd;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept_timeout addr=%h", addr);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic d_beat(input logic [1:0] src, input logic [2:0] opc, input logic [31:0] data,
                          input logic den, input logic cor);
        d_source  = src;
        d_opcode  = opc;
        d_data    = data;
        d_denied  = den;
        d_corrupt = cor;
        d_valid   = 1'b1;
        tick();
        d_valid   = 1'b0;
        d_denied  = 1'b0;
        d_corrupt = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got=%b exp=0", d_ready); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%b exp=0", a_valid); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err got=%b exp=0", proto_err); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_d_ready got=%b exp=1", d_ready); end
    endtask

    task automatic test_read_latency();
        do_reset();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1002; cmd_size = 2'd1; cmd_wdata = 32'hFFFF_FFFF;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL t1_cmd_ready got=%b exp=1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL t1_a_valid got=%b exp=1", a_valid); end
        checks++; if (a_opcode !== 3'd4) begin errors++; $display("FAIL t1_a_opcode got=%0d exp=4", a_opcode); end
        checks++; if (a_mask !== 4'b1100) begin errors++; $display("FAIL t1_a_mask got=%b exp=1100", a_mask); end
        checks++; if (a_address !== 32'h1002) begin errors++; $display("FAIL t1_a_address got=%h exp=00001002", a_address); end
        checks++; if (a_size !== 2'd1 || a_source !== 2'd0 || a_param !== 3'd0) begin errors++;
            $display("FAIL t1_a_fields got size=%0d src=%0d param=%0d exp 1/0/0", a_size, a_source, a_param); end
        checks++; if (a_data !== 32'd0) begin errors++; $display("FAIL t1_a_data got=%h exp=0", a_data); end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL t1_a_drop got=%b exp=0", a_valid); end
        d_source = 2'd0; d_opcode = 3'd1; d_data = 32'hBEEF_0000; d_valid = 1'b1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_rsp_early got=%b exp=0", rsp_valid); end
        tick();
        d_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL t1_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL t1_rdata got=%h exp=0000beef", rsp_rdata); end
        checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL t1_err got=%b exp=0", rsp_error); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_rsp_retire got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_write();
        do_reset();
        issue_cmd(1'b1, 32'h2001, 2'd0, 32'h0000_00A5);
        checks++; if (a_opcode !== 3'd0) begin errors++; $display("FAIL t2_a_opcode got=%0d exp=0", a_opcode); end
        checks++; if (a_mask !== 4'b0010) begin errors++; $display("FAIL t2_a_mask got=%b exp=0010", a_mask); end
        checks++; if (a_data !== 32'h0000_A500) begin errors++; $display("FAIL t2_a_data got=%h exp=0000a500", a_data); end
        tick();
        checks++; if (a_valid !== 1'b1 || a_data !== 32'h0000_A500) begin errors++;
            $display("FAIL t2_a_hold got valid=%b data=%h exp 1/0000a500", a_valid, a_data); end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        d_beat(2'd0, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin errors++;
            $display("FAIL t2_rsp got valid=%b err=%b exp 1/0", rsp_valid, rsp_error); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL t2_rdata got=%h exp=0", rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL t2_proto_err got=%b exp=0", proto_err); end
    endtask

    task automatic test_out_of_order();
        logic [1:0] order [4];
        do_reset();
        a_ready = 1'b1;
        for (int i = 0; i < 4; i++) issue_cmd(1'b0, 32'h100 + 32'(4 * i), 2'd2, 32'd0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; cmd_size = 2'd2;
        tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL t3_full_stall got=%b exp=0", cmd_ready); end
        order[0] = 2'd3; order[1] = 2'd1;
        for (int i = 0; i < 2; i++) d_beat(order[i], 3'd1, 32'hD0D0_0000 + 32'(order[i]), 1'b0, 1'b0);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t3_hold_order got=%b exp=0", rsp_valid); end
        d_beat(2'd0, 3'd1, 32'hD0D0_0000, 1'b0, 1'b0);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hD0D0_0000) begin errors++;
            $display("FAIL t3_rsp0 got valid=%b data=%h exp 1/d0d00000", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL t3_no_bypass got=%b exp=0", cmd_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hD0D0_0001) begin errors++;
            $display("FAIL t3_rsp1 got valid=%b data=%h exp 1/d0d00001", rsp_valid, rsp_rdata); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL t3_freed got=%b exp=1", cmd_ready); end
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t3_wait2 got=%b exp=0", rsp_valid); end
        checks++; if (a_valid !== 1'b1 || a_source !== 2'd0 || a_address !== 32'h200) begin errors++;
            $display("FAIL t3_fifth_a got valid=%b src=%0d addr=%h exp 1/0/00000200", a_valid, a_source, a_address); end
        d_beat(2'd2, 3'd1, 32'hD0D0_0002, 1'b0, 1'b0);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hD0D0_0002) begin errors++;
            $display("FAIL t3_rsp2 got valid=%b data=%h exp 1/d0d00002", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hD0D0_0003) begin errors++;
            $display("FAIL t3_rsp3 got valid=%b data=%h exp 1/d0d00003", rsp_valid, rsp_rdata); end
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t3_wait4 got=%b exp=0", rsp_valid); end
        d_beat(2'd0, 3'd1, 32'h0000_0055, 1'b0, 1'b0);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0055) begin errors++;
            $display("FAIL t3_rsp4 got valid=%b data=%h exp 1/00000055", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        a_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        do_reset();
        a_ready = 1'b1;
        issue_cmd(1'b0, 32'h3002, 2'd2, 32'd0);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL t4_no_a got=%b exp=0", a_valid); end
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'd0) begin errors++;
            $display("FAIL t4_mis_rsp got valid=%b err=%b data=%h exp 1/1/0", rsp_valid, rsp_error, rsp_rdata); end
        issue_cmd(1'b0, 32'h3005, 2'd0, 32'd0);
        checks++; if (a_valid !== 1'b1 || a_source !== 2'd1 || a_mask !== 4'b0010) begin errors++;
            $display("FAIL t4_next_a got valid=%b src=%0d mask=%b exp 1/1/0010", a_valid, a_source, a_mask); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t4_wait got=%b exp=0", rsp_valid); end
        d_beat(2'd1, 3'd1, 32'hFFFF_C3FF, 1'b0, 1'b0);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00C3 || rsp_error !== 1'b0) begin errors++;
            $display("FAIL t4_byte_rsp got valid=%b data=%h err=%b exp 1/000000c3/0", rsp_valid, rsp_rdata, rsp_error); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        issue_cmd(1'b0, 32'h3000, 2'd3, 32'd0);
        checks++; if (a_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin errors++;
            $display("FAIL t4_size3 got a_valid=%b rsp_valid=%b err=%b exp 0/1/1", a_valid, rsp_valid, rsp_error); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL t4_proto_err got=%b exp=0", proto_err); end
        a_ready = 1'b0;
    endtask

    task automatic test_errors();
        do_reset();
        a_ready = 1'b1;
        issue_cmd(1'b1, 32'h40, 2'd2, 32'h1234_5678);
        d_beat(2'd0, 3'd0, 32'd0, 1'b1, 1'b0);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin errors++;
            $display("FAIL t5_denied got valid=%b err=%b exp 1/1", rsp_valid, rsp_error); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        issue_cmd(1'b0, 32'h44, 2'd2, 32'd0);
        d_beat(2'd1, 3'd1, 32'hCAFE_F00D, 1'b0, 1'b1);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin errors++;
            $display("FAIL t5_corrupt got valid=%b err=%b exp 1/1", rsp_valid, rsp_error); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL t5_no_proto got=%b exp=0", proto_err); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        d_beat(2'd3, 3'd1, 32'd0, 1'b0, 1'b0);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL t5_stray got=%b exp=1", proto_err); end
        repeat (3) tick();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL t5_sticky got=%b exp=1", proto_err); end
        a_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL t6_clear got=%b exp=0", proto_err); end
        a_ready = 1'b1;
        issue_cmd(1'b0, 32'h600, 2'd2, 32'd0);
        tick();
        a_ready = 1'b0;
        issue_cmd(1'b0, 32'h604, 2'd2, 32'd0);
        checks++; if (a_valid !== 1'b1 || a_source !== 2'd1) begin errors++;
            $display("FAIL t6_held got valid=%b src=%0d exp 1/1", a_valid, a_source); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (a_valid !== 1'b0 || rsp_valid !== 1'b0 || d_ready !== 1'b0 || cmd_ready !== 1'b0) begin errors++;
            $display("FAIL t6_async got a_valid=%b rsp_valid=%b d_ready=%b cmd_ready=%b exp 0/0/0/0",
                     a_valid, rsp_valid, d_ready, cmd_ready); end
        checks++; if (a_address !== 32'd0 || a_source !== 2'd0 || rsp_rdata !== 32'd0) begin errors++;
            $display("FAIL t6_fields got addr=%h src=%0d rdata=%h exp 0/0/0", a_address, a_source, rsp_rdata); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (d_ready !== 1'b1 || proto_err !== 1'b0) begin errors++;
            $display("FAIL t6_release got d_ready=%b proto=%b exp 1/0", d_ready, proto_err); end
        d_beat(2'd0, 3'd1, 32'h1111_1111, 1'b0, 1'b0);
        checks++; if (proto_err !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
            $display("FAIL t6_late_d got proto=%b rsp_valid=%b exp 1/0", proto_err, rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write();
        test_out_of_order();
        test_misaligned();
        test_errors();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
